// File: rtl/mult_unit.sv
// mult_unit: 16-bit iterative shift-add multiplier with writeback handshake
// and misprediction kill.
//
// Ports
//   clk, rst_n      : clock and synchronous active-low reset
//   mult_inst_pkg   : [65] valid, [64:59] ROB index, [58:53] dest preg
//   op_a, op_b      : operands, sampled when a package is accepted
//   mis_pred        : flush request
//   mis_pred_indx   : ROB index of the mispredicted branch
//   rob_head        : oldest ROB entry, used as the age reference
//   cdb_grant       : writeback bus grant
//   mult_done       : one-cycle release of the upstream holding register
//   out_valid       : result present on the writeback bus
//   out_data        : low 16 bits of the product
//   out_rob         : ROB index of the result
//   out_preg        : destination physical register
//
// state | meaning
// IDLE  | waiting for a valid package
// BUSY  | 16 shift-add iterations
// DONE  | result on the bus, waiting for cdb_grant
// ABORT | killed operation, one-cycle release pulse
module mult_unit #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [65:0]       mult_inst_pkg,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              mis_pred,
  input  logic [5:0]        mis_pred_indx,
  input  logic [5:0]        rob_head,
  input  logic              cdb_grant,
  output logic              mult_done,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [5:0]        out_rob,
  output logic [5:0]        out_preg
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, ABORT} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] acc, mcand, mplier;
  logic [3:0]        cnt;
  logic [5:0]        rob_q, preg_q;

  logic              pkg_valid;
  logic [5:0]        pkg_rob, pkg_preg;
  logic [52:0]       unused_pkg_bits;
  logic [5:0]        age_mis, age_pkg, age_cap;
  logic              kill_pkg, kill_cap, accept;

  assign pkg_valid       = mult_inst_pkg[65];
  assign pkg_rob         = mult_inst_pkg[64:59];
  assign pkg_preg        = mult_inst_pkg[58:53];
  assign unused_pkg_bits = mult_inst_pkg[52:0];

  // Ages relative to the ROB head; 6-bit subtraction gives the mod-64 wrap.
  assign age_mis  = mis_pred_indx - rob_head;
  assign age_pkg  = pkg_rob - rob_head;
  assign age_cap  = rob_q - rob_head;
  // Only strictly younger entries are flushed; the branch itself survives.
  assign kill_pkg = mis_pred && (age_pkg > age_mis);
  assign kill_cap = mis_pred && (age_cap > age_mis);

  assign accept   = (state == IDLE) && pkg_valid && !kill_pkg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      rob_q  <= '0;
      preg_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        acc    <= '0;
        mcand  <= op_a;
        mplier <= op_b;
        cnt    <= '0;
        rob_q  <= pkg_rob;
        preg_q <= pkg_preg;
      end else if (state == BUSY) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 4'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    mult_done = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        if (pkg_valid) state_nxt = kill_pkg ? ABORT : BUSY;
      end
      BUSY: begin
        if (kill_cap)          state_nxt = ABORT;
        else if (cnt == 4'd15) state_nxt = DONE;
      end
      DONE: begin
        // A kill suppresses the result even when the bus is granted.
        if (kill_cap) begin
          state_nxt = ABORT;
        end else begin
          out_valid = 1'b1;
          if (cdb_grant) begin
            mult_done = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      ABORT: begin
        mult_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    out_data = out_valid ? acc    : '0;
    out_rob  = out_valid ? rob_q  : '0;
    out_preg = out_valid ? preg_q : '0;
  end

endmodule

// File: tb/tb_mult_unit.sv
module tb_mult_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [65:0] mult_inst_pkg;
  logic [15:0] op_a, op_b;
  logic        mis_pred;
  logic [5:0]  mis_pred_indx, rob_head;
  logic        cdb_grant;
  logic        mult_done, out_valid;
  logic [15:0] out_data;
  logic [5:0]  out_rob, out_preg;

  int total = 0;
  int bad   = 0;

  mult_unit #(.DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .mult_inst_pkg(mult_inst_pkg),
    .op_a(op_a), .op_b(op_b), .mis_pred(mis_pred),
    .mis_pred_indx(mis_pred_indx), .rob_head(rob_head),
    .cdb_grant(cdb_grant), .mult_done(mult_done), .out_valid(out_valid),
    .out_data(out_data), .out_rob(out_rob), .out_preg(out_preg)
  );

  always #5 clk = ~clk;

  // Reference model: plain product truncated to 16 bits.
  function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    return 16'(p % 65536);
  endfunction

  function automatic int age(input int x, input int head);
    return (x - head + 64) % 64;
  endfunction

  function automatic logic [65:0] mk_pkg(input logic [5:0] rob, input logic [5:0] preg);
    logic [65:0] p;
    p = {1'b1, rob, preg, 53'(($urandom() << 21) ^ $urandom())};
    return p;
  endfunction

  // Advance into the next cycle; inputs are driven just after the edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Full operation with grant tied high, package held until release.
  task automatic test_op(input logic [15:0] a, input logic [15:0] b,
                         input logic [5:0] rob, input logic [5:0] preg);
    logic [15:0] exp;
    exp = ref_mul(a, b);
    next_cycle();
    mult_inst_pkg = mk_pkg(rob, preg); op_a = a; op_b = b;
    cdb_grant = 1'b1; mis_pred = 1'b0;
    @(negedge clk);
    for (int c = 1; c <= 16; c++) begin
      next_cycle();
      op_a = 16'($urandom()); op_b = 16'($urandom());
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || mult_done !== 1'b0 || out_data !== 16'h0) begin
        bad++;
        $display("FAIL busy_quiet c=%0d: got valid=%b done=%b data=%h want 0 0 0000", c, out_valid, mult_done, out_data);
      end
    end
    next_cycle();
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || mult_done !== 1'b1 || out_data !== exp ||
        out_rob !== rob || out_preg !== preg) begin
      bad++;
      $display("FAIL result a=%h b=%h: got v=%b d=%b data=%h rob=%0d preg=%0d want 1 1 %h %0d %0d",
               a, b, out_valid, mult_done, out_data, out_rob, out_preg, exp, rob, preg);
    end
    next_cycle();
    mult_inst_pkg = '0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || mult_done !== 1'b0 || out_rob !== 6'd0) begin
      bad++;
      $display("FAIL after_done: got v=%b d=%b rob=%0d want 0 0 0", out_valid, mult_done, out_rob);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mult_inst_pkg = mk_pkg(6'd1, 6'd2); op_a = 16'h1; op_b = 16'h1;
    mis_pred = 1'b0; mis_pred_indx = '0; rob_head = '0; cdb_grant = 1'b1;
    for (int c = 0; c < 3; c++) next_cycle();
    @(negedge clk);
    total++;
    if (mult_done !== 1'b0 || out_valid !== 1'b0 || out_data !== 16'h0 ||
        out_rob !== 6'h0 || out_preg !== 6'h0) begin
      bad++;
      $display("FAIL reset_outputs: got d=%b v=%b data=%h rob=%0d preg=%0d want all 0",
               mult_done, out_valid, out_data, out_rob, out_preg);
    end
  endtask

  // First package presented in the very cycle reset deasserts.
  task automatic test_first_accept();
    @(posedge clk); #1;
    rst_n = 1'b1; mult_inst_pkg = mk_pkg(6'd7, 6'd9); op_a = 16'd3; op_b = 16'd5;
    for (int c = 1; c <= 17; c++) begin
      next_cycle();
      @(negedge clk);
    end
    total++;
    if (out_valid !== 1'b1 || mult_done !== 1'b1 || out_data !== 16'h000F ||
        out_rob !== 6'd7 || out_preg !== 6'd9) begin
      bad++;
      $display("FAIL first_accept: got v=%b d=%b data=%h rob=%0d preg=%0d want 1 1 000f 7 9",
               out_valid, mult_done, out_data, out_rob, out_preg);
    end
    next_cycle(); mult_inst_pkg = '0;
    @(negedge clk);
  endtask

  task automatic test_known();
    test_op(16'd3, 16'd5, 6'd7, 6'd9);
    test_op(16'hFFFF, 16'hFFFF, 6'd1, 6'd2);
    test_op(16'h0100, 16'h0100, 6'd3, 6'd4);
    test_op(16'h1234, 16'h0000, 6'd5, 6'd6);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      rob_head = 6'($urandom());
      test_op(16'($urandom()), 16'($urandom()), 6'($urandom()), 6'($urandom()));
    end
    rob_head = '0;
  endtask

  task automatic test_stall();
    logic [15:0] exp;
    exp = ref_mul(16'hABCD, 16'h0123);
    next_cycle();
    mult_inst_pkg = mk_pkg(6'd20, 6'd30); op_a = 16'hABCD; op_b = 16'h0123; cdb_grant = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      next_cycle();
      cdb_grant = (c == 20);
      @(negedge clk);
      if (c >= 17) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== exp || out_rob !== 6'd20 ||
            mult_done !== (c == 20)) begin
          bad++;
          $display("FAIL stall c=%0d: got v=%b d=%b data=%h rob=%0d want 1 %b %h 20",
                   c, out_valid, mult_done, out_data, out_rob, c == 20, exp);
        end
      end
    end
    next_cycle(); mult_inst_pkg = '0; cdb_grant = 1'b1;
    @(negedge clk);
  endtask

  // Flush in cycle 5 of an operation; kill decided by age from the model.
  task automatic test_kill_busy(input logic [5:0] idx);
    bit killed;
    bit saw_valid;
    rob_head = 6'd60; mis_pred_indx = 6'd62;
    killed = age(int'(idx), 60) > age(62, 60);
    saw_valid = 0;
    next_cycle();
    mult_inst_pkg = mk_pkg(idx, 6'd11); op_a = 16'd100; op_b = 16'd7;
    for (int c = 1; c <= 18; c++) begin
      next_cycle();
      mis_pred = (c == 5);
      if (c == 18) mult_inst_pkg = '0;
      @(negedge clk);
      if (out_valid === 1'b1) saw_valid = 1;
      if (c == 6 || c == 17) begin
        total++;
        if (mult_done !== ((c == 6) ? killed : !killed)) begin
          bad++;
          $display("FAIL kill_busy idx=%0d c=%0d: got done=%b want %b", idx, c, mult_done,
                   (c == 6) ? killed : !killed);
        end
      end
      if (killed && c == 7) mult_inst_pkg = '0;
    end
    total++;
    if (saw_valid !== !killed) begin
      bad++;
      $display("FAIL kill_busy_valid idx=%0d: got saw_valid=%b want %b", idx, saw_valid, !killed);
    end
    mis_pred = 1'b0; rob_head = '0;
  endtask

  // Kill arriving together with grant in the first DONE cycle.
  task automatic test_kill_done();
    rob_head = 6'd0; mis_pred_indx = 6'd5;
    next_cycle();
    mult_inst_pkg = mk_pkg(6'd10, 6'd12); op_a = 16'd9; op_b = 16'd9; cdb_grant = 1'b1;
    for (int c = 1; c <= 19; c++) begin
      next_cycle();
      mis_pred = (c == 17);
      @(negedge clk);
      if (c >= 17) begin
        total++;
        if (out_valid !== 1'b0 || mult_done !== (c == 18) || out_data !== 16'h0) begin
          bad++;
          $display("FAIL kill_done c=%0d: got v=%b d=%b data=%h want 0 %b 0000",
                   c, out_valid, mult_done, out_data, c == 18);
        end
      end
      if (c == 18) mult_inst_pkg = '0;
    end
  endtask

  // Killed package in IDLE: release next cycle, nothing captured.
  task automatic test_kill_idle();
    int dones;
    bit saw_valid;
    dones = 0; saw_valid = 0;
    rob_head = 6'd0; mis_pred_indx = 6'd10;
    next_cycle();
    mult_inst_pkg = mk_pkg(6'd20, 6'd3); mis_pred = 1'b1;
    @(negedge clk);
    next_cycle();
    mis_pred = 1'b0;
    @(negedge clk);
    total++;
    if (mult_done !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL kill_idle_abort: got d=%b v=%b want 1 0", mult_done, out_valid);
    end
    next_cycle(); mult_inst_pkg = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mult_done === 1'b1) dones++;
      if (out_valid === 1'b1) saw_valid = 1;
      next_cycle();
    end
    total++;
    if (dones != 0 || saw_valid) begin
      bad++;
      $display("FAIL kill_idle_quiet: got dones=%0d valid=%b want 0 0", dones, saw_valid);
    end
  endtask

  // Equal age to the branch must survive a flush held across the whole op.
  task automatic test_equal_age();
    logic [15:0] exp;
    exp = ref_mul(16'h0F0F, 16'h0033);
    rob_head = 6'd50; mis_pred_indx = 6'd3;
    next_cycle();
    mult_inst_pkg = mk_pkg(6'd3, 6'd8); op_a = 16'h0F0F; op_b = 16'h0033; mis_pred = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      next_cycle();
      @(negedge clk);
    end
    total++;
    if (out_valid !== 1'b1 || mult_done !== 1'b1 || out_data !== exp) begin
      bad++;
      $display("FAIL equal_age: got v=%b d=%b data=%h want 1 1 %h", out_valid, mult_done, out_data, exp);
    end
    next_cycle(); mult_inst_pkg = '0; mis_pred = 1'b0; rob_head = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_busy();
    int dones;
    logic [15:0] exp;
    dones = 0;
    exp = ref_mul(16'd21, 16'd2);
    next_cycle();
    mult_inst_pkg = mk_pkg(6'd4, 6'd4); op_a = 16'hFFF1; op_b = 16'h7777;
    for (int c = 1; c <= 8; c++) begin
      next_cycle();
      if (c == 8) rst_n = 1'b0;
      @(negedge clk);
      if (mult_done === 1'b1) dones++;
    end
    next_cycle();
    @(negedge clk);
    total++;
    if (mult_done !== 1'b0 || out_valid !== 1'b0 || out_data !== 16'h0 ||
        out_rob !== 6'h0 || out_preg !== 6'h0 || dones != 0) begin
      bad++;
      $display("FAIL reset_busy: got d=%b v=%b data=%h rob=%0d preg=%0d dones=%0d want all 0",
               mult_done, out_valid, out_data, out_rob, out_preg, dones);
    end
    // Reset released together with a new package.
    next_cycle();
    rst_n = 1'b1; mult_inst_pkg = mk_pkg(6'd33, 6'd44); op_a = 16'd21; op_b = 16'd2;
    for (int c = 1; c <= 17; c++) begin
      next_cycle();
      @(negedge clk);
    end
    total++;
    if (out_valid !== 1'b1 || mult_done !== 1'b1 || out_data !== exp || out_rob !== 6'd33) begin
      bad++;
      $display("FAIL reset_reaccept: got v=%b d=%b data=%h rob=%0d want 1 1 %h 33",
               out_valid, mult_done, out_data, out_rob, exp);
    end
    next_cycle(); mult_inst_pkg = '0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int done_cyc[$];
    logic [15:0] a2, b2, exp2, data35;
    int stage;
    a2 = 16'($urandom()); b2 = 16'($urandom());
    exp2 = ref_mul(a2, b2);
    data35 = '0; stage = 0;
    next_cycle();
    mult_inst_pkg = mk_pkg(6'd1, 6'd1); op_a = 16'($urandom()); op_b = 16'($urandom());
    cdb_grant = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      next_cycle();
      if (stage == 1) begin
        mult_inst_pkg = mk_pkg(6'd2, 6'd2); op_a = a2; op_b = b2; stage = 2;
      end else if (stage == 3) begin
        mult_inst_pkg = '0; stage = 4;
      end
      @(negedge clk);
      if (mult_done === 1'b1) begin
        done_cyc.push_back(c);
        if (stage == 2) data35 = out_data;
        stage++;
      end
    end
    total++;
    if (done_cyc.size() != 2 || done_cyc[0] != 17 || done_cyc[1] != 35) begin
      bad++;
      $display("FAIL b2b_timing: got %0d pulses first=%0d second=%0d want 2 at 17 35",
               done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1,
               (done_cyc.size() > 1) ? done_cyc[1] : -1);
    end
    total++;
    if (data35 !== exp2) begin
      bad++;
      $display("FAIL b2b_data: got %h want %h", data35, exp2);
    end
  endtask

  initial begin
    test_reset();
    test_first_accept();
    test_known();
    test_random();
    test_stall();
    test_kill_busy(6'd2);
    test_kill_busy(6'd61);
    test_kill_done();
    test_kill_idle();
    test_equal_age();
    test_reset_busy();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_unit.md
MULT_UNIT -- requirements
Module: mult_unit

Interface
REQ-001 Parameter DATA_W, default 16, operand and result width; only 16 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 mult_inst_pkg  input  66  package from issue/RF register: [65] valid, [64:59] ROB index, [58:53] dest preg, rest ignored.
REQ-005 op_a, op_b  input  16 each  operand values; valid whenever mult_inst_pkg[65]=1.
REQ-006 mis_pred  input  1  misprediction flush request.
REQ-007 mis_pred_indx  input  6  ROB index of the mispredicted branch.
REQ-008 rob_head  input  6  current ROB head, the oldest entry.
REQ-009 cdb_grant  input  1  writeback bus grant for this unit.
REQ-010 mult_done  output  1  one-cycle release pulse; frees the upstream holding register.
REQ-011 out_valid  output  1  result present on the writeback bus.
REQ-012 out_data  output  16  product, low 16 bits.
REQ-013 out_rob  output  6  ROB index of the result.
REQ-014 out_preg  output  6  destination physical register.

Function
REQ-015 States SHALL be IDLE, BUSY, DONE and ABORT, encoded in 2 bits.
REQ-016 age(x) = (x - rob_head) mod 64, computed with 6-bit wrap.
REQ-017 kill(idx) = mis_pred & (age(idx) > age(mis_pred_indx)); equal ages are never killed.
REQ-018 IDLE with pkg[65]=1 and ~kill(pkg[64:59]): capture op_a, op_b, ROB index and preg; clear accumulator and counter; go to BUSY.
REQ-019 IDLE with pkg[65]=1 and kill(pkg[64:59]): go to ABORT and capture nothing.
REQ-020 IDLE with pkg[65]=0: remain in IDLE.
REQ-021 BUSY, each cycle: if multiplier bit[0]=1 then acc += multiplicand (mod 2^16); multiplicand <<= 1; multiplier >>= 1; counter += 1.
REQ-022 BUSY SHALL run exactly 16 cycles; when counter reaches 15, go to DONE.
REQ-023 Latency: the accept cycle is cycle 0; cycles 1-16 are BUSY; out_valid first rises in cycle 17.
REQ-024 DONE: out_valid = ~kill(captured idx); out_data, out_rob and out_preg are driven from registers and held stable.
REQ-025 DONE with cdb_grant=1 and no kill: mult_done=1 for that cycle; go to IDLE.
REQ-026 DONE with cdb_grant=0: remain in DONE indefinitely, outputs unchanged, mult_done=0.
REQ-027 BUSY or DONE with kill(captured idx): go to ABORT; out_valid=0 in that cycle.
REQ-028 Kill SHALL take priority over cdb_grant in the same cycle.
REQ-029 ABORT: mult_done=1, out_valid=0 for exactly one cycle; go to IDLE.
REQ-030 mult_done SHALL be high only in (DONE & cdb_grant & ~kill) or in ABORT; never for two consecutive cycles.
REQ-031 out_valid SHALL be 0 in IDLE, BUSY and ABORT.
REQ-032 When out_valid=0, out_data, out_rob and out_preg SHALL be 0.
REQ-033 The package input is ignored outside IDLE; upstream holds it until mult_done.
REQ-034 In the cycle after mult_done, IDLE SHALL accept a new valid package (back-to-back, no bubble cycle).

Reset
REQ-035 rst_n=0 at a clock edge: state=IDLE; accumulator, counter and captured fields cleared; mult_done=0; out_valid=0; out_data=0; out_rob=0; out_preg=0.
REQ-036 Reset mid-BUSY or mid-DONE SHALL abandon the operation with no mult_done pulse.
REQ-037 The first package SHALL be accepted in the first cycle with rst_n=1.

Verification
REQ-038 op_a=3, op_b=5, rob=7, preg=9, cdb_grant=1 -> cycle 17: out_valid=1, out_data=0x000F, out_rob=7, out_preg=9, mult_done=1; cycle 18: IDLE.
REQ-039 0xFFFF*0xFFFF -> out_data=0x0001; 0x0100*0x0100 -> out_data=0x0000; 0x1234*0x0000 -> out_data=0x0000.
REQ-040 cdb_grant=0 for cycles 17-19, then 1 in cycle 20 -> out_valid=1 and data stable in cycles 17-20; mult_done=1 only in cycle 20.
REQ-041 rob_head=60, captured idx=2, mis_pred=1 with indx=62 in cycle 5 -> ABORT in cycle 6 with mult_done=1, out_valid never 1; same test with captured idx=61 -> no abort, result in cycle 17.
REQ-042 rst_n=0 in cycle 8 of BUSY -> all outputs 0 next cycle, no mult_done; new package accepted the cycle rst_n returns to 1.
REQ-043 Two packages issued back-to-back with grant tied 1 -> mult_done in cycles 17 and 35; second result correct.
